handshake_recv: RTL and testbench
=================================

HANDSHAKE_RECV -- requirements
Module: handshake_recv

Interface
REQ-001 Parameter WIDTH, default 4, data bus width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, flops in the req synchroniser; legal values 2 or 3.
REQ-003 sclk  input  1  receive-domain clock, rising-edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  4-phase request from the sending domain; asynchronous to sclk.
REQ-006 data_in  input  WIDTH  sender data, stable while req is high.
REQ-007 ack  output  1  4-phase acknowledge to the sender, registered.
REQ-008 out_data  output  WIDTH  captured word to downstream, registered.
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  downstream accepts out_data when high with out_valid.

Function
REQ-011 req SHALL pass through SYNC_STAGES flops; only the last stage output (req_s) SHALL drive logic.
REQ-012 FSM SHALL have states IDLE and ACKH; reset state IDLE.
REQ-013 Buffer is free in a cycle when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-014 IDLE: req_s=1 and buffer free -> capture data_in into out_data, set out_valid=1, set ack=1, go ACKH, all on the same edge.
REQ-015 IDLE: req_s=1 and buffer not free -> stay IDLE, ack stays 0; this is the only backpressure to the sender.
REQ-016 ACKH: req_s=0 -> ack=0, go IDLE; otherwise hold ack=1 and no capture.
REQ-017 Exactly one capture per req high phase; a new capture requires req_s to be seen low in ACKH first.
REQ-018 out_valid SHALL clear on an edge with out_ready=1 and out_valid=1, unless a capture occurs on that edge, in which case out_valid stays 1 and out_data takes the new word.
REQ-019 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-020 Latency: req rising before edge 1 with buffer free -> ack and out_valid high after edge SYNC_STAGES+1.
REQ-021 out_ready with out_valid=0 SHALL have no effect.

Reset
REQ-022 reset_n low SHALL clear asynchronously: sync flops, state=IDLE, ack=0, out_valid=0, out_data=0; the transfer count is also cleared when compiled in.
REQ-023 Reset mid-transfer SHALL drop ack immediately; after release, a still-high req is captured again as a new transfer.

Configuration
REQ-024 Macro HANDSHAKE_RECV_CNT_EN defined: add output xfer_cnt (16 bits), incremented once per capture, wrapping 16'hFFFF -> 0.
REQ-025 HANDSHAKE_RECV_CNT_EN undefined: no xfer_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-026 Shared package handshake_pkg SHALL hold the FSM state enumeration (IDLE, ACKH) and the counter width constant (16).
REQ-027 The synchroniser SHALL be a sub-module sync_bit (parameter SYNC_STAGES, async active-low reset to 0), reusable for the sender's ack synchroniser.

Verification
REQ-028 SYNC_STAGES=2, out_ready=1, req high with data_in=4'hA -> ack=1 and out_data=4'hA with out_valid=1 after edge 3; req low -> ack=0 two to three edges later.
REQ-029 out_ready=0 with a word pending, new req with data_in=4'h5 -> ack stays 0 and out_data keeps its old value; out_ready=1 for one cycle -> 4'h5 captured on that same edge and out_valid stays 1.
REQ-030 Back-to-back transfers 4'h1, 4'h2, 4'h3 with out_ready=1 -> exactly three out_valid acceptances in order and no duplicates.
REQ-031 req held high for 20 cycles -> exactly one capture, and ack stays high throughout.
REQ-032 reset_n pulsed low while in ACKH with req=1 -> ack=0 and out_valid=0 immediately; after release, one new capture.
REQ-033 HANDSHAKE_RECV_CNT_EN defined, counter preloaded near wrap, two transfers -> xfer_cnt reads 16'hFFFF then 16'h0000.

Source files
------------

// File: rtl/handshake_pkg.sv
// Purpose: shared types and constants for the 4-phase handshake receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: hs_state_t (IDLE, ACKH) receiver FSM states; XFER_CNT_W transfer counter width.
package handshake_pkg;

  typedef enum logic {
    IDLE = 1'b0,  // waiting for a synchronised req high
    ACKH = 1'b1   // word captured, ack high, waiting for req to drop
  } hs_state_t;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/sync_bit.sv
// Purpose: multi-flop synchroniser for one asynchronous level signal (req here, ack on the sender side).
// Latency: SYNC_STAGES sclk edges from d to q.
// Backpressure: none; q simply tracks d.
// Ports: sclk clock, reset_n async active-low reset (stages clear to 0), d async input, q synchronised output.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sclk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  // Only the last stage leaves the synchroniser; earlier stages may be metastable.
  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/handshake_recv.sv
// Purpose: receive side of a 4-phase req/ack crossing; captures data_in into a one-word output buffer.
// Latency: req rise -> ack and out_valid high after SYNC_STAGES+1 sclk edges when the buffer is free.
// Backpressure: a full buffer (out_valid=1, out_ready=0) holds ack low, stalling the sender.
// Ports: sclk, reset_n (async active-low); req/data_in from sender, ack back to sender;
//        out_data/out_valid/out_ready valid-ready port to downstream.
// Option: define HANDSHAKE_RECV_CNT_EN to add xfer_cnt, a 16-bit wrapping count of captures.
module handshake_recv
  import handshake_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef HANDSHAKE_RECV_CNT_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

  logic      req_s;
  logic      buf_free;
  logic      capture;
  hs_state_t state_q;
  hs_state_t state_d;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .sclk   (sclk),
    .reset_n(reset_n),
    .d      (req),
    .q      (req_s)
  );

  // The buffer can take a new word on the same edge the old one is consumed.
  assign buf_free = !out_valid || out_ready;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && buf_free) begin
          capture = 1'b1;
          state_d = ACKH;
        end
      end
      ACKH: begin
        // No capture here: a new word needs req_s seen low first.
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ack mirrors the next state so it is a clean flop output towards the sender.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      ack <= 1'b0;
    end else begin
      ack <= (state_d == ACKH);
    end
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= data_in;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HANDSHAKE_RECV_CNT_EN
  // Natural modulo-2^16 wrap.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_cnt <= '0;
    end else if (capture) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_recv.sv
// Purpose: self-checking bench for handshake_recv (WIDTH=4, SYNC_STAGES=2).
// Latency: inputs driven 1 time unit after rising edges; buffer acceptances sampled on falling edges.
// Backpressure: out_ready driven per vector / per sequence; a scoreboard queue tracks expected words.
module tb_handshake_recv;

  logic       sclk = 1'b0;
  logic       reset_n;
  logic       req;
  logic [3:0] data_in;
  logic       ack;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef HANDSHAKE_RECV_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  handshake_recv #(
    .WIDTH      (4),
    .SYNC_STAGES(2)
  ) dut (
    .sclk     (sclk),
    .reset_n  (reset_n),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef HANDSHAKE_RECV_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 sclk = ~sclk;

  int         checks  = 0;
  int         errors  = 0;
  int         accepts = 0;
  int         pushes  = 0;
  logic [3:0] sb_q[$];

  typedef struct {
    logic [3:0] data;
    logic       rdy;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    sb_q.push_back(d);
    pushes++;
  endtask

  // Counts edges until ack reaches lvl, bounded at 50 edges.
  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack !== lvl && n < 50);
    check("ack_reached", ack, lvl);
  endtask

  // One full 4-phase transfer; expects ack/out_valid after exp_lat edges.
  task automatic xfer(input logic [3:0] d, input int exp_lat);
    int n;
    data_in = d;
    req     = 1'b1;
    push(d);
    wait_ack(1'b1, n);
    check("ack_rise_latency", n, exp_lat);
    check("valid_at_ack", out_valid, 1'b1);
    check("data_at_ack", out_data, d);
    req = 1'b0;
    wait_ack(1'b0, n);
    check("ack_fall_2_to_3", (n >= 2 && n <= 3), 1'b1);
  endtask

  // Scoreboard: every acceptance (valid & ready before an edge) pops one expected word.
  initial begin
    forever begin
      @(negedge sclk);
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        accepts++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept_unexpected actual=%0h required=none", out_data);
        end else begin
          check("accept_data", out_data, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   n;
    int   lows;
    int   bad;
    int   a0;

    vecs[0] = '{data: 4'hA, rdy: 1'b1, lat: 3};
    vecs[1] = '{data: 4'h1, rdy: 1'b1, lat: 3};
    vecs[2] = '{data: 4'h2, rdy: 1'b1, lat: 3};
    vecs[3] = '{data: 4'h3, rdy: 1'b0, lat: 3};
    vecs[4] = '{data: 4'hF, rdy: 1'b1, lat: 3};
    vecs[5] = '{data: 4'h0, rdy: 1'b1, lat: 3};

    reset_n   = 1'b0;
    req       = 1'b0;
    data_in   = 4'h0;
    out_ready = 1'b0;
    #12;
    check("reset_ack", ack, 1'b0);
    check("reset_valid", out_valid, 1'b0);
    check("reset_data", out_data, 4'h0);
    #1;
    reset_n = 1'b1;
    tick();

    // Table: back-to-back transfers, some left pending until the next vector.
    for (int i = 0; i < 6; i++) begin
      out_ready = vecs[i].rdy;
      xfer(vecs[i].data, vecs[i].lat);
    end
    tick();
    tick();
    check("table_drained", sb_q.size(), 0);

    // Backpressure: pending 7, new req 5 must wait for one ready cycle.
    out_ready = 1'b0;
    xfer(4'h7, 3);
    data_in = 4'h5;
    req     = 1'b1;
    push(4'h5);
    lows = 0;
    bad  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack !== 1'b0) lows++;
      if (out_data !== 4'h7 || out_valid !== 1'b1) bad++;
    end
    check("bp_ack_held_low", lows, 0);
    check("bp_data_held", bad, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ack_same_edge", ack, 1'b1);
    check("bp_valid_stays", out_valid, 1'b1);
    check("bp_new_data", out_data, 4'h5);
    req = 1'b0;
    wait_ack(1'b0, n);
    out_ready = 1'b1;
    tick();
    tick();
    check("bp_drained_valid", out_valid, 1'b0);

    // req held for 20 cycles: one capture, ack high throughout.
    a0      = accepts;
    data_in = 4'hE;
    req     = 1'b1;
    push(4'hE);
    lows = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i >= 3 && ack !== 1'b1) lows++;
    end
    check("hold_ack_high", lows, 0);
    req = 1'b0;
    wait_ack(1'b0, n);
    repeat (3) tick();
    check("hold_one_capture", accepts - a0, 1);

    // Reset while in ACKH with a pending word.
    out_ready = 1'b0;
    data_in   = 4'hC;
    req       = 1'b1;
    push(4'hC);
    wait_ack(1'b1, n);
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_ack", ack, 1'b0);
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_data", out_data, 4'h0);
    sb_q.delete();
    #2;
    reset_n = 1'b1;
    a0      = accepts;
    push(4'hC);
    out_ready = 1'b1;
    wait_ack(1'b1, n);
    check("rst_recapture_latency", n, 3);
    check("rst_recapture_data", out_data, 4'hC);
    req = 1'b0;
    wait_ack(1'b0, n);
    repeat (2) tick();
    check("rst_one_capture", accepts - a0, 1);

    // out_ready with nothing pending changes nothing.
    repeat (3) tick();
    check("idle_ready_valid", out_valid, 1'b0);
    check("idle_ready_data", out_data, 4'hC);

`ifdef HANDSHAKE_RECV_CNT_EN
    dut.xfer_cnt = 16'hFFFE;
    xfer(4'h6, 3);
    check("cnt_ffff", xfer_cnt, 16'hFFFF);
    xfer(4'h9, 3);
    check("cnt_wrap", xfer_cnt, 16'h0000);
    tick();
    tick();
`endif

    check("sb_empty", sb_q.size(), 0);
    check("accept_total", accepts, pushes - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
